// File: rtl/muldiv_sequencer.sv
// Shift-add multiplier / restoring divider sequencer driving a shared external 16-bit ALU.
// Optional divide support is compiled in with `define MULDIV_DIV_EN.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [16:0] alu_res
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MOVE = 3'b010;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [15:0] m_q;      // multiplicand for MUL, divisor for DIV
  logic [31:0] p, p_n;   // MUL: product P; DIV: {R[15:0], Q}
  logic        abort;
  logic        err_q;
  logic [31:0] result_q;

  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
  assign result = result_q;
  assign err    = err_q;

  always_comb begin
    state_n  = state;
    p_n      = p;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_MOVE;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_n = op ? DIV : MUL;
`else
          // Unsupported DIV passes one cycle through MUL with abort set, matching div-by-zero timing.
          state_n = MUL;
`endif
        end
      end
      MUL: begin
        if (abort) begin
          state_n = DONE;
        end else begin
          alu_ctrl = ALU_ADD;
          alu_a    = p[31:16];
          alu_b    = p[0] ? m_q : '0;
          p_n      = {alu_res, p[15:1]};
          if (cnt == 4'd15) state_n = DONE;
        end
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        if (abort) begin
          state_n = DONE;
        end else begin
          // S = {R, Q[15]} is p[31:15]; R never exceeds 16 bits so S[16] is p[31].
          alu_ctrl = ALU_SUB;
          alu_a    = p[30:15];
          alu_b    = m_q;
          if (p[31] || !alu_res[16]) p_n = {alu_res[15:0], p[14:0], 1'b1};
          else                       p_n = {p[30:15], p[14:0], 1'b0};
          if (cnt == 4'd15) state_n = DONE;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      m_q      <= '0;
      p        <= '0;
      abort    <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        m_q   <= op ? opb : opa;
        p     <= {16'h0000, op ? opa : opb};
        cnt   <= '0;
        err_q <= 1'b0;
`ifdef MULDIV_DIV_EN
        abort <= op && (opb == '0);
`else
        abort <= op;
`endif
      end else if (busy) begin
        p   <= p_n;
        cnt <= cnt + 4'd1;
        if (state_n == DONE) begin
          err_q <= abort;
          if (!abort) begin
            result_q <= p_n;
          end else begin
`ifdef MULDIV_DIV_EN
            result_q <= {p[15:0], 16'hFFFF};
`else
            result_q <= '0;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: behavioural ALU, arithmetic reference model,
// directed corner cases and randomized operations.
module tb_muldiv_sequencer;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [15:0] opa, opb;
  logic        busy, done, err;
  logic [31:0] result;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [16:0] alu_res;
  logic        sub_seen = 1'b0;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  // Shared ALU as seen by the sequencer.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_res = {alu_a < alu_b, alu_a - alu_b};
      default: alu_res = '0;
    endcase
  end

  always @(posedge clk) if (alu_ctrl == 3'b001) sub_seen <= 1'b1;

  function automatic logic [32:0] ref_op(input logic o, input logic [15:0] a, input logic [15:0] b);
    if (!o)      return {1'b0, 32'(a) * 32'(b)};
    if (!DIV_EN) return {1'b1, 32'h0};
    if (b == 0)  return {1'b1, a, 16'hFFFF};
    return {1'b0, 16'(a % b), 16'(a / b)};
  endfunction

  function automatic int ref_lat(input logic o, input logic [15:0] b);
    return (o && (!DIV_EN || b == 0)) ? 2 : 17;
  endfunction

  // Drives one request starting at the current negedge and collects what the DUT did.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                        output int lat, output logic [31:0] res, output logic e,
                        output logic busy_ok, output logic hold_ok, output logic tail_ok);
    logic [31:0] prev;
    int cyc;
    start = 1'b1; op = o; opa = a; opb = b;
    prev = result;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_ok = 1'b1; hold_ok = 1'b1; tail_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) hold_ok = 1'b0;
      if (cyc == pulse_at) begin
        start = 1'b1; op = ~o; opa = 16'($urandom); opb = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    lat = done ? cyc : -1;
    res = result;
    e   = err;
    if (busy) busy_ok = 1'b0;
    if (alu_ctrl !== 3'b010 || alu_a !== 16'h0 || alu_b !== 16'h0) tail_ok = 1'b0;
    if (cyc == pulse_at) begin
      start = 1'b1; opa = 16'($urandom); opb = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    if (done !== 1'b0 || busy !== 1'b0) tail_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (err !== 1'b0)         begin bad++; $display("FAIL reset_err got %b want 0", err); end
    total++; if (result !== 32'h0)     begin bad++; $display("FAIL reset_result got %h want 0", result); end
    total++; if (alu_ctrl !== 3'b010)  begin bad++; $display("FAIL reset_alu_ctrl got %b want 010", alu_ctrl); end
    total++; if ({alu_a, alu_b} !== 32'h0) begin bad++; $display("FAIL reset_alu_ops got %h want 0", {alu_a, alu_b}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'd3, 16'hFFFF, 16'd100, 16'hFFFF, 16'd100};
    logic [15:0] vb [5] = '{16'd5, 16'hFFFF, 16'd7,   16'd1,    16'd0};
    logic        vo [5] = '{1'b0,  1'b0,     1'b1,    1'b1,     1'b1};
    int lat; logic [31:0] res; logic e, bok, hok, tok;
    logic [32:0] exp;
    for (int i = 0; i < 5; i++) begin
      exp = ref_op(vo[i], va[i], vb[i]);
      run_op(vo[i], va[i], vb[i], 0, lat, res, e, bok, hok, tok);
      total++; if (lat != ref_lat(vo[i], vb[i])) begin bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ref_lat(vo[i], vb[i])); end
      total++; if (res !== exp[31:0]) begin bad++; $display("FAIL dir%0d_result got %h want %h", i, res, exp[31:0]); end
      total++; if (e !== exp[32])     begin bad++; $display("FAIL dir%0d_err got %b want %b", i, e, exp[32]); end
      total++; if (!(bok && hok && tok)) begin bad++; $display("FAIL dir%0d_handshake got busy/hold/tail %b%b%b want 111", i, bok, hok, tok); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; logic e, bok, hok, tok;
    logic o; logic [15:0] a, b;
    logic [32:0] exp;
    for (int i = 0; i < 30; i++) begin
      o = 1'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      exp = ref_op(o, a, b);
      run_op(o, a, b, 0, lat, res, e, bok, hok, tok);
      total++; if (lat != ref_lat(o, b)) begin bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, ref_lat(o, b)); end
      total++; if ({e, res} !== exp)     begin bad++; $display("FAIL rnd%0d_op%0d_%h_%h got %b/%h want %b/%h", i, o, a, b, e, res, exp[32], exp[31:0]); end
      total++; if (!(bok && hok && tok)) begin bad++; $display("FAIL rnd%0d_handshake got busy/hold/tail %b%b%b want 111", i, bok, hok, tok); end
    end
  endtask

  task automatic test_restart();
    int lat; logic [31:0] res; logic e, bok, hok, tok;
    logic [32:0] exp;
    exp = ref_op(1'b0, 16'd1234, 16'd77);
    run_op(1'b0, 16'd1234, 16'd77, 5, lat, res, e, bok, hok, tok);
    total++; if (lat != 17)            begin bad++; $display("FAIL restart_latency got %0d want 17", lat); end
    total++; if ({e, res} !== exp)     begin bad++; $display("FAIL restart_result got %b/%h want %b/%h", e, res, exp[32], exp[31:0]); end
    total++; if (!(bok && hok && tok)) begin bad++; $display("FAIL restart_handshake got %b%b%b want 111", bok, hok, tok); end
    exp = ref_op(1'b0, 16'd9, 16'd11);
    run_op(1'b0, 16'd9, 16'd11, 17, lat, res, e, bok, hok, tok);
    total++; if ({e, res} !== exp)     begin bad++; $display("FAIL start_in_done_result got %h want %h", res, exp[31:0]); end
    total++; if (!tok)                 begin bad++; $display("FAIL start_in_done_ignored got tail %b want 1", tok); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic e, bok, hok, tok;
    logic seen_done;
    start = 1'b1; op = DIV_EN; opa = 16'd5000; opb = 16'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midrst_result got %h want 0", result); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL midrst_done got %b want 0", done); end
    run_op(1'b0, 16'd2, 16'd2, 0, lat, res, e, bok, hok, tok);
    total++; if (lat != 17 || res !== 32'd4 || e !== 1'b0) begin bad++; $display("FAIL midrst_mul2x2 got lat %0d res %h err %b want 17/4/0", lat, res, e); end
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL idle_spurious_done got %b want 0", seen_done); end
  endtask

  task automatic test_no_sub();
    total++; if (sub_seen !== DIV_EN) begin bad++; $display("FAIL alu_sub_issued got %b want %b", sub_seen, DIV_EN); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_mid();
    test_no_sub();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have port op, input, 1, operation select: 0 = MUL, 1 = DIV.
REQ-005 SHALL have ports opa and opb, input, 16 each, unsigned multiplicand/dividend (opa) and multiplier/divisor (opb).
REQ-006 SHALL have port busy, output, 1, high from the cycle after start is accepted until the cycle done is high.
REQ-007 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-008 SHALL have port result, output, 32, MUL: full product; DIV: {remainder[15:0], quotient[15:0]}; held until the next accepted start.
REQ-009 SHALL have port err, output, 1, valid with done; divide-by-zero or unsupported op.
REQ-010 SHALL have ports alu_a and alu_b, output, 16 each, operands driven to the shared 16-bit ALU.
REQ-011 SHALL have port alu_ctrl, output, 3, ALU code: 000 ADD, 001 SUB, 010 MOVE.
REQ-012 SHALL have port alu_res, input, 17, ALU return; bits [15:0] hold the sum/difference, bit 16 holds the ADD carry-out or SUB borrow (1 = A<B).

Function
REQ-013 SHALL implement the FSM states IDLE, MUL, DIV and DONE; IDLE+start -> MUL or DIV; after 16 iterations -> DONE; DONE -> IDLE unconditionally.
REQ-014 SHALL, in IDLE with start=1, capture opa and opb, clear the iteration counter (4-bit) and clear err.
REQ-015 SHALL, in MUL, drive ADD with alu_a = P[31:16] and alu_b = P[0] ? mcand : 0, then update P <= {alu_res[16], alu_res[15:0], P[15:1]}; P SHALL be initialised to {16'h0, opb}, with mcand = opa.
REQ-016 SHALL, in DIV, keep a 17-bit remainder R (init 0) and a quotient Q (init opa); each iteration form S = {R[15:0], Q[15]} and drive SUB with alu_a = S[15:0] and alu_b = divisor; if S[16]=1 or alu_res[16]=0 the iteration SHALL set R <= S - divisor and shift Q left with LSB 1, otherwise it SHALL set R <= S and shift Q left with LSB 0.
REQ-017 SHALL have a latency of exactly 17 cycles: start sampled in cycle 0, iterations in cycles 1-16, done=1 in cycle 17.
REQ-018 SHALL drive alu_a=0, alu_b=0 and alu_ctrl=010 in IDLE and DONE.
REQ-019 SHALL handle DIV with opb=0 by entering DONE next cycle with no iterations, result={opa, 16'hFFFF} and err=1.
REQ-020 SHALL ignore start while busy or in DONE, with no effect on state or outputs.
REQ-021 SHALL update result only in the DONE-entry cycle; done SHALL never be high on two consecutive cycles.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, force IDLE, busy=0, done=0, err=0, result=0 and counter=0, and drive the ALU outputs per REQ-018.
REQ-023 SHALL, on rst mid-operation, abandon the operation with no done pulse; start SHALL be accepted on the first cycle after rst deasserts.

Configuration
REQ-024 SHALL include the DIV state and the REQ-016/REQ-019 behaviour only when the macro MULDIV_DIV_EN is defined.
REQ-025 SHALL, without MULDIV_DIV_EN, treat op=1 like divide-by-zero timing: DONE next cycle, result=0, err=1, and no ALU SUB ever issued; MUL behaviour SHALL be unchanged.

Verification
REQ-026 SHALL cover: MUL opa=3, opb=5 -> done in cycle 17, result=32'h0000000F, err=0.
REQ-027 SHALL cover: MUL opa=16'hFFFF, opb=16'hFFFF -> result=32'hFFFE0001 (carry path exercised).
REQ-028 SHALL cover: DIV opa=100, opb=7 -> result=32'h0002000E, err=0; DIV 16'hFFFF/1 -> 32'h0000FFFF.
REQ-029 SHALL cover: DIV opa=100, opb=0 -> done in cycle 2, result=32'h0064FFFF, err=1; without MULDIV_DIV_EN -> result=0, err=1.
REQ-030 SHALL cover: start re-pulsed in cycle 5 of a MUL -> ignored, original result and timing unchanged.
REQ-031 SHALL cover: rst asserted in cycle 8 of a DIV -> busy=0 and result=0 next cycle, no done; new MUL 2*2 then yields 4.
